// File: rtl/mem_access.sv
// Memory-access pipeline stage: word loads/stores over a request/grant/rvalid
// data port, branch resolution for fetch, and the MEM/WB register set.
module mem_access #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_result_exe_mem,
  input  logic        zero_exe_mem,
  input  logic [31:0] PC_branch_exe_mem,
  input  logic [31:0] rs2_exe_mem,
  input  logic [4:0]  write_reg_exe_mem,
  input  logic        ctrl_branch_exe_mem,
  input  logic        ctrl_mem_read_exe_mem,
  input  logic        ctrl_mem_to_reg_exe_mem,
  input  logic        ctrl_mem_write_exe_mem,
  input  logic        ctrl_write_reg_exe_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        stall_mem,
  output logic        pc_src_mem,
  output logic [31:0] PC_branch_mem,
  output logic [31:0] read_data_mem_wb,
  output logic [31:0] alu_result_mem_wb,
  output logic [4:0]  write_reg_mem_wb,
  output logic        ctrl_mem_to_reg_mem_wb,
  output logic        ctrl_write_reg_mem_wb,
  output logic        mem_err_mem_wb
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wcnt;
  logic             op, is_store, at_limit;
  logic             done, timeout, load_done;

  // A request with both read and write set is treated as a store.
  assign op         = ctrl_mem_read_exe_mem | ctrl_mem_write_exe_mem;
  assign is_store   = ctrl_mem_write_exe_mem;
  assign at_limit   = (wcnt == CNT_W'(WAIT_LIMIT - 1));

  assign dmem_we    = ctrl_mem_write_exe_mem;
  assign dmem_addr  = {alu_result_exe_mem[31:2], 2'b00};
  assign dmem_wdata = rs2_exe_mem;

  assign pc_src_mem    = ctrl_branch_exe_mem & zero_exe_mem;
  assign PC_branch_mem = PC_branch_exe_mem;
  assign stall_mem     = op & ~done;

  // Next-state and handshake decode.
  always_comb begin
    state_nxt = state;
    dmem_req  = 1'b0;
    done      = 1'b0;
    timeout   = 1'b0;
    load_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (op) begin
          dmem_req = 1'b1;
          if (dmem_gnt) begin
            if (is_store) done = 1'b1;
            else          state_nxt = S_WAIT;
          end else begin
            state_nxt = S_REQ;
          end
        end
      end
      S_REQ: begin
        dmem_req = 1'b1;
        if (dmem_gnt && is_store) begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end else if (dmem_gnt) begin
          state_nxt = S_WAIT;
        end
        // A load grant on the last allowed cycle still times out.
        if (!done && at_limit) begin
          timeout   = 1'b1;
          done      = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (dmem_rvalid) begin
          done      = 1'b1;
          load_done = 1'b1;
          state_nxt = S_IDLE;
        end else if (at_limit) begin
          timeout   = 1'b1;
          done      = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, wait counter and MEM/WB registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                  <= S_IDLE;
      wcnt                   <= '0;
      read_data_mem_wb       <= '0;
      alu_result_mem_wb      <= '0;
      write_reg_mem_wb       <= '0;
      ctrl_mem_to_reg_mem_wb <= 1'b0;
      ctrl_write_reg_mem_wb  <= 1'b0;
      mem_err_mem_wb         <= 1'b0;
    end else begin
      state <= state_nxt;
      wcnt  <= (state == S_IDLE) ? '0 : wcnt + CNT_W'(1);
      if (stall_mem) begin
        ctrl_mem_to_reg_mem_wb <= 1'b0;
        ctrl_write_reg_mem_wb  <= 1'b0;
        mem_err_mem_wb         <= 1'b0;
      end else begin
        alu_result_mem_wb      <= alu_result_exe_mem;
        write_reg_mem_wb       <= write_reg_exe_mem;
        ctrl_mem_to_reg_mem_wb <= ctrl_mem_to_reg_exe_mem;
        ctrl_write_reg_mem_wb  <= ctrl_write_reg_exe_mem;
        mem_err_mem_wb         <= timeout;
        if (load_done)    read_data_mem_wb <= dmem_rdata;
        else if (timeout) read_data_mem_wb <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: expected MEM/WB records are queued as each
// cycle is driven and compared after the following clock edge.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_result_exe_mem, PC_branch_exe_mem, rs2_exe_mem, dmem_rdata;
  logic        zero_exe_mem, ctrl_branch_exe_mem, ctrl_mem_read_exe_mem;
  logic        ctrl_mem_to_reg_exe_mem, ctrl_mem_write_exe_mem, ctrl_write_reg_exe_mem;
  logic [4:0]  write_reg_exe_mem;
  logic        dmem_gnt, dmem_rvalid;
  logic        dmem_req, dmem_we, stall_mem, pc_src_mem;
  logic [31:0] dmem_addr, dmem_wdata, PC_branch_mem, read_data_mem_wb, alu_result_mem_wb;
  logic [4:0]  write_reg_mem_wb;
  logic        ctrl_mem_to_reg_mem_wb, ctrl_write_reg_mem_wb, mem_err_mem_wb;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] rd;
    logic [4:0]  wreg;
    logic        m2r;
    logic        wr;
    logic        err;
  } mwb_t;

  mwb_t exp_q[$];
  mwb_t hold;
  int   n_checks = 0;
  int   n_errs   = 0;

  mem_access #(.WAIT_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .alu_result_exe_mem(alu_result_exe_mem), .zero_exe_mem(zero_exe_mem),
    .PC_branch_exe_mem(PC_branch_exe_mem), .rs2_exe_mem(rs2_exe_mem),
    .write_reg_exe_mem(write_reg_exe_mem), .ctrl_branch_exe_mem(ctrl_branch_exe_mem),
    .ctrl_mem_read_exe_mem(ctrl_mem_read_exe_mem),
    .ctrl_mem_to_reg_exe_mem(ctrl_mem_to_reg_exe_mem),
    .ctrl_mem_write_exe_mem(ctrl_mem_write_exe_mem),
    .ctrl_write_reg_exe_mem(ctrl_write_reg_exe_mem),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .stall_mem(stall_mem), .pc_src_mem(pc_src_mem), .PC_branch_mem(PC_branch_mem),
    .read_data_mem_wb(read_data_mem_wb), .alu_result_mem_wb(alu_result_mem_wb),
    .write_reg_mem_wb(write_reg_mem_wb), .ctrl_mem_to_reg_mem_wb(ctrl_mem_to_reg_mem_wb),
    .ctrl_write_reg_mem_wb(ctrl_write_reg_mem_wb), .mem_err_mem_wb(mem_err_mem_wb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    alu_result_exe_mem      = '0;
    PC_branch_exe_mem       = '0;
    rs2_exe_mem             = '0;
    write_reg_exe_mem       = '0;
    zero_exe_mem            = 1'b0;
    ctrl_branch_exe_mem     = 1'b0;
    ctrl_mem_read_exe_mem   = 1'b0;
    ctrl_mem_to_reg_exe_mem = 1'b0;
    ctrl_mem_write_exe_mem  = 1'b0;
    ctrl_write_reg_exe_mem  = 1'b0;
    dmem_gnt                = 1'b0;
    dmem_rvalid             = 1'b0;
    dmem_rdata              = '0;
  endtask

  // Instruction retires into MEM/WB; read_data given explicitly.
  task automatic push_commit(input logic [31:0] alu, input logic [31:0] rd,
                             input logic [4:0] wreg, input logic m2r,
                             input logic wr, input logic err);
    hold.alu = alu; hold.rd = rd; hold.wreg = wreg;
    hold.m2r = m2r; hold.wr = wr; hold.err = err;
    exp_q.push_back(hold);
  endtask

  // Bubble: data fields hold, control and error bits cleared.
  task automatic push_bubble();
    hold.m2r = 1'b0; hold.wr = 1'b0; hold.err = 1'b0;
    exp_q.push_back(hold);
  endtask

  task automatic push_reset();
    push_commit('0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // Advance one clock and compare MEM/WB against the oldest queued record.
  task automatic tick(input string tag);
    mwb_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errs++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, ".alu"},  alu_result_mem_wb, e.alu);
      check({tag, ".rd"},   read_data_mem_wb, e.rd);
      check({tag, ".wreg"}, 32'(write_reg_mem_wb), 32'(e.wreg));
      check({tag, ".m2r"},  32'(ctrl_mem_to_reg_mem_wb), 32'(e.m2r));
      check({tag, ".wr"},   32'(ctrl_write_reg_mem_wb), 32'(e.wr));
      check({tag, ".err"},  32'(mem_err_mem_wb), 32'(e.err));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    hold = '{alu: '0, rd: '0, wreg: '0, m2r: 1'b0, wr: 1'b0, err: 1'b0};
    clear_inputs();
    rst = 1'b1;
    push_reset(); tick("rst0");
    push_reset(); tick("rst1");
    rst = 1'b0;
    #1;
    check("rst.stall", 32'(stall_mem), 32'd0);
    check("rst.req",   32'(dmem_req), 32'd0);

    // ALU instruction
    alu_result_exe_mem = 32'h1234; write_reg_exe_mem = 5'd5; ctrl_write_reg_exe_mem = 1'b1;
    #1;
    check("alu.stall", 32'(stall_mem), 32'd0);
    check("alu.req",   32'(dmem_req), 32'd0);
    push_commit(32'h1234, hold.rd, 5'd5, 1'b0, 1'b1, 1'b0);
    tick("alu");

    // Store to 0x103, grant after two cycles
    clear_inputs();
    alu_result_exe_mem = 32'h103; rs2_exe_mem = 32'hCAFEF00D; write_reg_exe_mem = 5'd7;
    ctrl_mem_write_exe_mem = 1'b1;
    #1;
    check("st.addr",  dmem_addr, 32'h100);
    check("st.wdata", dmem_wdata, 32'hCAFEF00D);
    check("st.we",    32'(dmem_we), 32'd1);
    for (int i = 0; i < 2; i++) begin
      check("st.req_w",   32'(dmem_req), 32'd1);
      check("st.stall_w", 32'(stall_mem), 32'd1);
      push_bubble(); tick("st.bub");
    end
    dmem_gnt = 1'b1;
    #1;
    check("st.stall_g", 32'(stall_mem), 32'd0);
    push_commit(32'h103, hold.rd, 5'd7, 1'b0, 1'b0, 1'b0);
    tick("st.done");

    // Load from 0x200, immediate grant, rvalid three cycles later
    clear_inputs();
    alu_result_exe_mem = 32'h200; write_reg_exe_mem = 5'd9;
    ctrl_mem_read_exe_mem = 1'b1; ctrl_mem_to_reg_exe_mem = 1'b1; ctrl_write_reg_exe_mem = 1'b1;
    dmem_gnt = 1'b1;
    #1;
    check("ld.req0", 32'(dmem_req), 32'd1);
    check("ld.we",   32'(dmem_we), 32'd0);
    check("ld.stall0", 32'(stall_mem), 32'd1);
    push_bubble(); tick("ld.bub0");
    dmem_gnt = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("ld.req_w",   32'(dmem_req), 32'd0);
      check("ld.stall_w", 32'(stall_mem), 32'd1);
      push_bubble(); tick("ld.bub");
    end
    dmem_rvalid = 1'b1; dmem_rdata = 32'hA5A5A5A5;
    #1;
    check("ld.stall_d", 32'(stall_mem), 32'd0);
    push_commit(32'h200, 32'hA5A5A5A5, 5'd9, 1'b1, 1'b1, 1'b0);
    tick("ld.done");

    // Timeout: grant, rvalid never arrives, WAIT_LIMIT = 4
    dmem_rvalid = 1'b0; dmem_rdata = '0;
    alu_result_exe_mem = 32'h300; write_reg_exe_mem = 5'd10; dmem_gnt = 1'b1;
    #1;
    check("to.req0", 32'(dmem_req), 32'd1);
    push_bubble(); tick("to.bub0");
    dmem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("to.stall_w", 32'(stall_mem), 32'd1);
      push_bubble(); tick("to.bub");
    end
    #1;
    check("to.stall_d", 32'(stall_mem), 32'd0);
    push_commit(32'h300, 32'h0, 5'd10, 1'b1, 1'b1, 1'b1);
    tick("to.done");

    // Back-to-back load; rvalid alongside the grant must be ignored
    alu_result_exe_mem = 32'h304; write_reg_exe_mem = 5'd11;
    dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hBAD0BAD0;
    #1;
    check("b2b.req0",  32'(dmem_req), 32'd1);
    check("b2b.stall", 32'(stall_mem), 32'd1);
    push_bubble(); tick("b2b.bub");
    dmem_gnt = 1'b0; dmem_rdata = 32'h12345678;
    #1;
    check("b2b.stall_d", 32'(stall_mem), 32'd0);
    push_commit(32'h304, 32'h12345678, 5'd11, 1'b1, 1'b1, 1'b0);
    tick("b2b.done");

    // Branch resolution is combinational
    clear_inputs();
    alu_result_exe_mem = 32'h44; ctrl_branch_exe_mem = 1'b1;
    zero_exe_mem = 1'b1; PC_branch_exe_mem = 32'h80;
    #1;
    check("br.src1", 32'(pc_src_mem), 32'd1);
    check("br.pc",   PC_branch_mem, 32'h80);
    push_commit(32'h44, hold.rd, 5'd0, 1'b0, 1'b0, 1'b0);
    tick("br1");
    zero_exe_mem = 1'b0;
    #1;
    check("br.src0", 32'(pc_src_mem), 32'd0);
    push_commit(32'h44, hold.rd, 5'd0, 1'b0, 1'b0, 1'b0);
    tick("br0");

    // Reset while in WAIT, then a stale rvalid
    clear_inputs();
    alu_result_exe_mem = 32'h400; write_reg_exe_mem = 5'd12;
    ctrl_mem_read_exe_mem = 1'b1; ctrl_mem_to_reg_exe_mem = 1'b1; ctrl_write_reg_exe_mem = 1'b1;
    dmem_gnt = 1'b1;
    push_bubble(); tick("rw.bub0");
    dmem_gnt = 1'b0;
    push_bubble(); tick("rw.bub1");
    rst = 1'b1;
    clear_inputs();
    push_reset(); tick("rw.rst");
    rst = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'hDEADBEEF;
    #1;
    check("rw.req",   32'(dmem_req), 32'd0);
    check("rw.stall", 32'(stall_mem), 32'd0);
    push_commit(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick("rw.late");
    // An immediately granted store completes only if the FSM is in IDLE
    dmem_rvalid = 1'b0; dmem_rdata = '0;
    alu_result_exe_mem = 32'h500; ctrl_mem_write_exe_mem = 1'b1; dmem_gnt = 1'b1;
    #1;
    check("rw.idle_stall", 32'(stall_mem), 32'd0);
    push_commit(32'h500, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick("rw.st");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
